// File: rtl/mul_sequencer_if.sv
// Request/result handshake bundle for mul_sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface mul_sequencer_if #(
  parameter int W = 32
) ();
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         flush;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] result;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, result_ready,
    input  req_ready, result_valid, result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, result_ready,
    output req_ready, result_valid, result
  );
endinterface

// File: rtl/mul_sequencer.sv
// Sign-magnitude multiplier that time-shares one HW x HW unsigned shift-add
// multiplier over four partial products, then fixes the sign.
//
// state | meaning
// IDLE  | waiting for a request (req_ready = 1)
// MUL   | accumulating partial product cnt_q (0..3)
// FIX   | two's-complement the accumulator if the true product is negative
// DONE  | result presented until result_ready
module mul_sequencer #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_sequencer_if.slave  bus
);
  localparam int HW = W / 2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [1:0]     op_q, op_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;

  logic           sign_a, sign_b;
  logic [W-1:0]   mag_a, mag_b;
  logic [HW-1:0]  mul_a, mul_b;
  logic [W-1:0]   prod;
  logic [2*W-1:0] prod_ext;
  logic [2*W-1:0] add_term;

  // Magnitudes are W-bit unsigned so the most-negative operand maps to 2^(W-1).
  always_comb begin
    sign_a = ((bus.req_op == OP_MULH) || (bus.req_op == OP_MULHSU)) && bus.req_a[W-1];
    sign_b = (bus.req_op == OP_MULH) && bus.req_b[W-1];
    mag_a  = sign_a ? -bus.req_a : bus.req_a;
    mag_b  = sign_b ? -bus.req_b : bus.req_b;
  end

  always_comb begin
    mul_a = a_q[HW-1:0];
    mul_b = b_q[HW-1:0];
    case (cnt_q)
      2'd0: begin mul_a = a_q[HW-1:0]; mul_b = b_q[HW-1:0]; end
      2'd1: begin mul_a = a_q[HW-1:0]; mul_b = b_q[W-1:HW]; end
      2'd2: begin mul_a = a_q[W-1:HW]; mul_b = b_q[HW-1:0]; end
      default: begin mul_a = a_q[W-1:HW]; mul_b = b_q[W-1:HW]; end
    endcase
  end

  // The single shared radix-2 (one bit per partial product) multiplier.
  always_comb begin
    prod = '0;
    for (int i = 0; i < HW; i++) begin
      if (mul_b[i]) begin
        prod = prod + ({{HW{1'b0}}, mul_a} << i);
      end
    end
  end

  always_comb begin
    prod_ext = {{W{1'b0}}, prod};
    case (cnt_q)
      2'd0:    add_term = prod_ext;
      2'd1,
      2'd2:    add_term = prod_ext << HW;
      default: add_term = prod_ext << W;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_d    = bus.req_op;
            a_d     = mag_a;
            b_d     = mag_b;
            neg_d   = sign_a ^ sign_b;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = ST_MUL;
          end
        end
        ST_MUL: begin
          acc_d = acc_q + add_term;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          if (neg_q) begin
            acc_d = -acc_q;
          end
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    bus.req_ready    = (state_q == ST_IDLE);
    bus.result_valid = (state_q == ST_DONE);
    bus.result       = '0;
    if (state_q == ST_DONE) begin
      bus.result = (op_q == OP_MUL) ? acc_q[W-1:0] : acc_q[2*W-1:W];
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized checks of mul_sequencer against a full-width
// arithmetic reference product.
module tb_mul_sequencer;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_sequencer_if #(.W(W)) bus ();

  mul_sequencer #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: extend each operand per its signedness and take the 2W-bit product.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Entry/exit point: 1 time unit after a rising edge with the block idle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] exp;
    int n;
    exp = model(op, a, b);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.result_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_op    = 2'($urandom_range(0, 3));
    n = 0;
    while (!bus.result_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(5));
    chk({tag, "_result"}, 64'(bus.result), 64'(exp));
    chk({tag, "_busy"}, 64'(bus.req_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(bus.result_valid), 64'(1));
      chk({tag, "_hold_result"}, 64'(bus.result), 64'(exp));
      chk({tag, "_hold_busy"}, 64'(bus.req_ready), 64'(0));
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(bus.result_valid), 64'(0));
    chk({tag, "_post_result"}, 64'(bus.result), 64'(0));
    chk({tag, "_post_ready"}, 64'(bus.req_ready), 64'(1));
  endtask

  task automatic no_result(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.flush        = 1'b0;
    bus.result_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_result_valid", 64'(bus.result_valid), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ff");
    chk("mul_ff_const", 64'(model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_ff");
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ff");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
    run_op(2'b10, 32'h0000_0002, 32'h8000_0000, 0, "mulhsu_2");
    run_op(2'b00, 32'h0001_2345, 32'h0000_0010, 10, "mul_bp");

    // Flush while step 2 is being fed.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_req_ready", 64'(bus.req_ready), 64'(1));
    chk("flush_result_valid", 64'(bus.result_valid), 64'(0));
    no_result(8, "flush_no_result");
    run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 0, "after_flush");

    // A request coinciding with flush is not taken.
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'd6;
    bus.req_b     = 32'd7;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_req_ignored", 64'(bus.req_ready), 64'(1));
    no_result(8, "flush_req_no_result");

    // Asynchronous reset in the middle of MUL.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'd7;
    bus.req_b     = 32'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("arst_result_valid", 64'(bus.result_valid), 64'(0));
    chk("arst_result", 64'(bus.result), 64'(0));
    #1 rst_n = 1'b1;
    no_result(8, "arst_no_result");
    run_op(2'b00, 32'd3, 32'd5, 0, "after_rst");

    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = 32'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'h8000_0000;
        2: rb = $urandom | 32'h8000_0000;
        default: rb = 32'($urandom_range(0, 255));
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
